// File: rtl/udp_chan_arbiter.sv
// udp_chan_arbiter
//   Round-robin packet scheduler that shares one UDP transmit byte stream
//   among NCH first-word-fall-through channel FIFOs. Once any channel holds a
//   full packet it is granted, and the block emits a 2-byte header followed by
//   PKT_BYTES payload bytes popped from that FIFO, then idles for GAP_CYCLES.
//
// Ports
//   clk, rst_n   125 MHz clock, asynchronous active-low reset
//   enable       permits new grants (looked at only in IDLE)
//   tx_busy      UDP transmitter busy; a packet starts only while low
//   ch_level     per-channel FIFO occupancy in bytes, channel i at [16i+15:16i]
//   ch_data      per-channel FIFO head byte, channel i at [8i+7:8i]
//   ch_rd_en     pop strobe, one-hot or zero
//   tx_data      byte to the UDP transmitter (registered)
//   tx_valid     tx_data qualifier (registered)
//   grant        one-hot owner of the current packet, zero in IDLE
//   active       high in every state except IDLE
//   pkt_cnt      packets completed since reset, wraps 0xFFFF -> 0
//   dbg_state_o  current FSM state encoding, for observation only
//
// Handshake: there is no back-pressure on the transmit side. tx_valid is a
// pure qualifier; once a packet starts it runs to completion regardless of
// tx_busy or enable, so the downstream must accept one byte every cycle while
// tx_valid is high. tx_busy only gates the start of a packet.
module udp_chan_arbiter #(
  parameter int NCH        = 4,
  parameter int PKT_BYTES  = 1024,
  parameter int GAP_CYCLES = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              tx_busy,
  input  logic [NCH*16-1:0] ch_level,
  input  logic [NCH*8-1:0]  ch_data,
  output logic [NCH-1:0]    ch_rd_en,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic [NCH-1:0]    grant,
  output logic              active,
  output logic [15:0]       pkt_cnt,
  output logic [2:0]        dbg_state_o
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR0    = 3'd1,
    S_HDR1    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_GAP     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [NCH-1:0]  grant_q, grant_d;
  logic [IW-1:0]   ch_q, ch_d;
  logic [IW-1:0]   last_q, last_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     gap_q, gap_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;
  logic [7:0]      seq_q [NCH];
  logic            seq_inc;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;

  logic [7:0]      head [NCH];
  logic [NCH-1:0]  eligible;
  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      head[i]     = ch_data[8*i +: 8];
      eligible[i] = (ch_level[16*i +: 16] >= 16'(PKT_BYTES));
    end
  end

  // Round-robin search: start one past the last served channel and wrap, so
  // the most recently served channel has the lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = '0;
    for (int off = 1; off <= NCH; off++) begin
      cand = IW'((int'(last_q) + off) % NCH);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ch_d       = ch_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    pkt_cnt_d  = pkt_cnt_q;
    seq_inc    = 1'b0;
    tx_data_d  = 8'h00;
    tx_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (enable && !tx_busy && found) begin
          ch_d    = pick;
          last_d  = pick;
          grant_d = NCH'(1) << pick;
          state_d = S_HDR0;
        end
      end
      S_HDR0: begin
        tx_valid_d = 1'b1;
        tx_data_d  = {4'hA, 4'(ch_q)};
        state_d    = S_HDR1;
      end
      S_HDR1: begin
        tx_valid_d = 1'b1;
        tx_data_d  = seq_q[ch_q];
        cnt_d      = 16'd0;
        state_d    = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        // The FIFO is first-word-fall-through: the byte popped this cycle is
        // the head byte presented this cycle.
        tx_valid_d = 1'b1;
        tx_data_d  = head[ch_q];
        cnt_d      = cnt_q + 16'd1;
        if (cnt_q == 16'(PKT_BYTES - 1)) begin
          state_d   = S_GAP;
          gap_d     = 16'd0;
          seq_inc   = 1'b1;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_q == 16'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ch_q       <= '0;
      last_q     <= IW'(NCH - 1);
      cnt_q      <= 16'd0;
      gap_q      <= 16'd0;
      pkt_cnt_q  <= 16'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ch_q       <= ch_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      pkt_cnt_q  <= pkt_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) seq_q[i] <= 8'h00;
    end else if (seq_inc) begin
      seq_q[ch_q] <= seq_q[ch_q] + 8'd1;
    end
  end

  // Pops are decoded straight from the registered state so the strobe lines
  // up with the head byte that is being captured into tx_data this cycle.
  assign ch_rd_en    = (state_q == S_PAYLOAD) ? grant_q : '0;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign grant       = grant_q;
  assign active      = (state_q != S_IDLE);
  assign pkt_cnt     = pkt_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_udp_chan_arbiter.sv
// tb_udp_chan_arbiter
//   Bench for udp_chan_arbiter. A FIFO model feeds the channels; a packet-level
//   reference model predicts each transmitted byte and the cycle it appears,
//   plus the expected grant/active/pop/pkt_cnt, from the scheduling rules.
module tb_udp_chan_arbiter;

  localparam int NCH = 4;
  localparam int PKT = 16;
  localparam int GAP = 12;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              tx_busy = 1'b0;
  logic [NCH*16-1:0] ch_level = '0;
  logic [NCH*8-1:0]  ch_data = '0;
  logic [NCH-1:0]    ch_rd_en;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic [NCH-1:0]    grant;
  logic              active;
  logic [15:0]       pkt_cnt;
  logic [2:0]        dbg_state;

  always #4 clk = ~clk;

  udp_chan_arbiter #(.NCH(NCH), .PKT_BYTES(PKT), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tx_busy(tx_busy),
    .ch_level(ch_level), .ch_data(ch_data), .ch_rd_en(ch_rd_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .grant(grant), .active(active),
    .pkt_cnt(pkt_cnt), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  // FIFO model (only the posedge process touches the queues)
  logic [7:0] fifo_q [NCH][$];
  int         fill_total [NCH];
  int         filled     [NCH];
  int         flush_total = 0;
  int         flushed     = 0;

  // Reference model
  int             m_last, m_next_free, m_have, m_e, m_ch;
  int             m_pkts_total = 0;
  logic [7:0]     m_seq [NCH];
  logic [15:0]    m_pkt_cnt;
  logic [NCH-1:0] m_grant, m_rd;
  logic           m_active;

  function automatic void model_reset();
    m_last      = NCH - 1;
    m_next_free = 0;
    m_have      = 0;
    m_e         = 0;
    m_ch        = 0;
    m_pkt_cnt   = 16'd0;
    m_grant     = '0;
    m_rd        = '0;
    m_active    = 1'b0;
    for (int i = 0; i < NCH; i++) m_seq[i] = 8'h00;
    exp_q.delete();
    exp_cyc_q.delete();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edge process: packet-level model decision, FIFO pops/fills, then drive
  // the FIFO view to the DUT shortly after the edge.
  always @(posedge clk) begin
    int pick;
    int c;
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (cyc >= m_next_free && enable && !tx_busy) begin
        pick = -1;
        for (int off = 1; off <= NCH; off++) begin
          c = (m_last + off) % NCH;
          if (pick < 0 && fifo_q[c].size() >= PKT) pick = c;
        end
        if (pick >= 0) begin
          m_last = pick;
          m_have = 1;
          m_e    = cyc;
          m_ch   = pick;
          m_next_free = cyc + PKT + GAP + 3;
          m_pkts_total++;
          exp_q.push_back(8'hA0 | 8'(pick));  exp_cyc_q.push_back(cyc + 1);
          exp_q.push_back(m_seq[pick]);        exp_cyc_q.push_back(cyc + 2);
          for (int k = 0; k < PKT; k++) begin
            exp_q.push_back(fifo_q[pick][k]);  exp_cyc_q.push_back(cyc + 3 + k);
          end
          m_seq[pick] = m_seq[pick] + 8'd1;
        end
      end
      m_grant  = '0;
      m_rd     = '0;
      m_active = 1'b0;
      if (m_have != 0 && cyc <= m_e + 1 + PKT + GAP) begin
        m_grant  = NCH'(1) << m_ch;
        m_active = 1'b1;
        if (cyc >= m_e + 2 && cyc <= m_e + 1 + PKT) m_rd = NCH'(1) << m_ch;
      end
      if (m_have != 0 && cyc == m_e + 2 + PKT) m_pkt_cnt = m_pkt_cnt + 16'd1;
    end
    for (int i = 0; i < NCH; i++)
      if (ch_rd_en[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
    if (flushed != flush_total) begin
      flushed = flush_total;
      for (int i = 0; i < NCH; i++) fifo_q[i].delete();
    end
    for (int i = 0; i < NCH; i++)
      while (filled[i] < fill_total[i]) begin
        fifo_q[i].push_back(8'($urandom_range(0, 255)));
        filled[i]++;
      end
    #1;
    for (int i = 0; i < NCH; i++) begin
      ch_level[16*i +: 16] = 16'(fifo_q[i].size());
      ch_data[8*i +: 8]    = (fifo_q[i].size() > 0) ? fifo_q[i][0] : 8'h00;
    end
  end

  // Monitor: pops expected bytes whenever the DUT presents one.
  int low_run   = 0;
  int have_prev = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      low_run   = 0;
      have_prev = 0;
    end else begin
      if (tx_valid) begin
        if (have_prev != 0 && low_run > 0) begin
          n_tests++;
          if (low_run < GAP + 1) begin
            n_fail++;
            $display("FAIL gap_len: got %0d low cycles, expected at least %0d (cycle %0d)",
                     low_run, GAP + 1, cyc);
          end
        end
        if (exp_q.size() == 0) begin
          check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
          check("tx_time", cyc, exp_cyc_q.pop_front());
        end
        have_prev = 1;
        low_run   = 0;
      end else begin
        low_run++;
        if (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
          check("tx_missing", 32'h0, {24'h0, exp_q.pop_front()});
          void'(exp_cyc_q.pop_front());
        end
      end
      check("ctrl{grant,active,rd_en,pkt_cnt}",
            {7'h0, grant, active, ch_rd_en, pkt_cnt},
            {7'h0, m_grant, m_active, m_rd, m_pkt_cnt});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input int ch, input int nbytes);
    fill_total[ch] += nbytes;
  endtask

  task automatic flush();
    flush_total++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_outputs{txd,txv,rd,grant,active,pkt}",
          {tx_data, tx_valid, ch_rd_en, grant, active, pkt_cnt},
          {8'h00, 1'b0, {NCH{1'b0}}, {NCH{1'b0}}, 1'b0, 16'h0000});
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int t;
    t = 0;
    while (m_pkts_total < target && t < budget) begin
      tick(1);
      t++;
    end
    check("wait_pkts_timeout", 32'(m_pkts_total >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && (m_have == 0 || cyc >= m_next_free)) && t < budget) begin
      tick(1);
      t++;
    end
    check("wait_idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int a0, a2, t;
    for (int i = 0; i < NCH; i++) begin
      fill_total[i] = 0;
      filled[i]     = 0;
    end
    model_reset();
    do_reset();

    // Single packet from channel 0.
    fill(0, PKT);
    enable = 1'b1;
    wait_pkts(1, 200);
    wait_idle(200);
    check("pkt_cnt_one", {16'h0, pkt_cnt}, 32'd1);
    check("ch0_all_popped", 32'(fifo_q[0].size()), 32'd0);

    // All channels eligible: round robin 0,1,2,3,0,...
    do_reset();
    base = m_pkts_total;
    for (int i = 0; i < NCH; i++) fill(i, 3 * PKT);
    wait_pkts(base + 12, 12 * (PKT + GAP + 3) + 50);
    wait_idle(200);
    check("pkt_cnt_rr", {16'h0, pkt_cnt}, 32'd12);

    // tx_busy blocks the start only.
    do_reset();
    tx_busy = 1'b1;
    fill(2, PKT);
    tick(40);
    check("busy_no_grant", {28'h0, grant}, 32'd0);
    base = m_pkts_total;
    tx_busy = 1'b0;
    wait_pkts(base + 1, 50);
    tick(PKT / 2 + 3);
    tx_busy = 1'b1;
    wait_idle(200);
    tx_busy = 1'b0;
    check("pkt_cnt_busy", {16'h0, pkt_cnt}, 32'd1);

    // enable dropped mid-payload.
    base = m_pkts_total;
    fill(1, 2 * PKT);
    wait_pkts(base + 1, 50);
    tick(PKT / 2 + 3);
    enable = 1'b0;
    tick(3 * (PKT + GAP + 3));
    check("disabled_no_grant", {28'h0, grant}, 32'd0);
    check("pkt_cnt_disabled", {16'h0, pkt_cnt}, 32'd2);
    enable = 1'b1;
    wait_pkts(base + 2, 50);
    wait_idle(200);
    check("pkt_cnt_reenabled", {16'h0, pkt_cnt}, 32'd3);

    // Reset in the middle of a payload.
    base = m_pkts_total;
    fill(3, 2 * PKT);
    wait_pkts(base + 1, 50);
    tick(2 + PKT / 2);
    do_reset();
    check("pkt_cnt_after_abort", {16'h0, pkt_cnt}, 32'd0);
    wait_pkts(base + 2, 50);
    check("pkt_cnt_inflight", {16'h0, pkt_cnt}, 32'd0);
    wait_idle(200);
    check("pkt_cnt_after_resume", {16'h0, pkt_cnt}, 32'd1);

    // Long random run: channel 1 wraps its sequence number.
    flush();
    tick(1);
    do_reset();
    a0 = $urandom_range(2, 5);
    a2 = $urandom_range(2, 5);
    fill(1, 258 * PKT);
    fill(0, a0 * PKT + $urandom_range(0, PKT - 1));
    fill(2, a2 * PKT + $urandom_range(0, PKT - 1));
    tick(1);
    t = 0;
    while (t < 40000 && !(fifo_q[0].size() < PKT && fifo_q[1].size() < PKT &&
                          fifo_q[2].size() < PKT && fifo_q[3].size() < PKT)) begin
      tx_busy = ($urandom_range(0, 3) == 0);
      tick(1);
      t++;
    end
    tx_busy = 1'b0;
    wait_idle(200);
    check("pkt_cnt_long", {16'h0, pkt_cnt}, 32'(258 + a0 + a2));
    check("ch1_drained", 32'(fifo_q[1].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(8 * 90000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

endmodule
